// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the digital-clock digit-counter chain.
// Optional auto-repeat of btn_inc is built when AUTO_REPEAT_EN is defined.
module clock_set_ctrl #(
    parameter int BLINK_HALF    = 8,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_cin,
    output logic       min_cin,
    output logic       hr_cin,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       blank_sec
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    if (BLINK_HALF < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("clock_set_ctrl: illegal parameter combination");
    end

    mode_t          mode_reg, mode_next;
    mode_t          inc_sel_reg;
    logic           mode_hist_reg, inc_hist_reg;
    logic           tick_q_reg, inc_q_reg;
    logic [BW-1:0]  blink_cnt_reg;
    logic           phase_reg;
    logic           mode_rise, inc_rise, rep_fire, inc_fire;

    assign mode_rise = btn_mode & ~mode_hist_reg;
    assign inc_rise  = btn_inc & ~inc_hist_reg;

    // Next-state: one advance per btn_mode rise, wrapping back to RUN.
    always_comb begin
        mode_next = mode_reg;
        if (mode_rise) begin
            case (mode_reg)
                RUN:     mode_next = SET_HR;
                SET_HR:  mode_next = SET_MIN;
                SET_MIN: mode_next = SET_SEC;
                default: mode_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_reg <= RUN;
        end else begin
            mode_reg <= mode_next;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic          rep_arm_reg;
    logic [RW-1:0] rep_cnt_reg;

    assign rep_fire = rep_arm_reg & btn_inc & ~mode_rise & (mode_reg != RUN)
                    & (rep_cnt_reg == RW'(REPEAT_DELAY));

    // Arming only on a rise inside the current SET mode keeps repeat off
    // after a mode change until btn_inc has been released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_arm_reg <= 1'b0;
            rep_cnt_reg <= '0;
        end else if (!btn_inc || mode_rise || mode_reg == RUN) begin
            rep_arm_reg <= 1'b0;
            rep_cnt_reg <= '0;
        end else if (inc_rise) begin
            rep_arm_reg <= 1'b1;
            rep_cnt_reg <= RW'(1);
        end else if (rep_arm_reg) begin
            if (rep_fire) begin
                rep_cnt_reg <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
            end else begin
                rep_cnt_reg <= rep_cnt_reg + RW'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign inc_fire = (inc_rise & (mode_reg != RUN)) | rep_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_hist_reg <= 1'b1;
            inc_hist_reg  <= 1'b1;
            tick_q_reg    <= 1'b0;
            inc_q_reg     <= 1'b0;
            inc_sel_reg   <= RUN;
        end else begin
            mode_hist_reg <= btn_mode;
            inc_hist_reg  <= btn_inc;
            tick_q_reg    <= tick & (mode_reg == RUN);
            inc_q_reg     <= inc_fire;
            inc_sel_reg   <= mode_reg;
        end
    end

    // Blink restarts visible whenever the field changes or gets bumped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (mode_rise || inc_fire || mode_reg == RUN) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
        end
    end

    assign sec_cin = reset & (tick_q_reg | (inc_q_reg & (inc_sel_reg == SET_SEC)));
    assign min_cin = reset & (((mode_reg == RUN) & sec_carry)
                            | (inc_q_reg & (inc_sel_reg == SET_MIN)));
    assign hr_cin  = reset & (((mode_reg == RUN) & min_carry)
                            | (inc_q_reg & (inc_sel_reg == SET_HR)));

    assign mode      = mode_reg;
    assign blank_hr  = reset & (mode_reg == SET_HR)  & phase_reg;
    assign blank_min = reset & (mode_reg == SET_MIN) & phase_reg;
    assign blank_sec = reset & (mode_reg == SET_SEC) & phase_reg;

endmodule
